// File: rtl/wiper_sweep_driver.sv
// Wiper sweep driver: turns the off/slow/fast speed command into an
// out-back-park arm sweep shown on a one-hot LED bar.
// The arm never stops mid-arc; a speed change during a sweep only changes the step rate.
// Optional feature: define WIPER_MIST_EN to make speed==3 a one-shot fast "mist" sweep.
// Without that macro, speed==3 behaves exactly like off.
module wiper_sweep_driver #(
  parameter int unsigned NPOS       = 6,
  parameter int unsigned SLOW_DIV   = 8,
  parameter int unsigned FAST_DIV   = 3,
  parameter int unsigned DWELL_SLOW = 4
) (
  input  logic                    clk_2,
  input  logic                    reset,
  input  logic [1:0]              speed,
  output logic [$clog2(NPOS)-1:0] arm_pos,
  output logic [NPOS-1:0]         led_bar,
  output logic                    moving,
  output logic                    parked,
  output logic [7:0]              sweep_count
);

  localparam int unsigned PW      = $clog2(NPOS);
  localparam int unsigned CNT_MAX = (SLOW_DIV > DWELL_SLOW) ? SLOW_DIV : DWELL_SLOW;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  // The last outward step starts from POS_TURN; the last return step starts from position 1.
  localparam logic [PW-1:0] POS_TURN   = PW'(NPOS - 2);
  localparam logic [PW-1:0] POS_ONE    = PW'(1);
  localparam logic [CW-1:0] SLOW_LAST  = CW'(SLOW_DIV - 1);
  localparam logic [CW-1:0] FAST_LAST  = CW'(FAST_DIV - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_SLOW - 1);

  typedef enum logic [1:0] {
    PARK       = 2'd0,
    SWEEP_OUT  = 2'd1,
    SWEEP_BACK = 2'd2,
    DWELL      = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   arm_pos_q, arm_pos_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      sweep_count_q, sweep_count_d;
  logic [NPOS-1:0] led_bar_q, led_bar_d;
  logic            moving_q, moving_d;
  logic            parked_q, parked_d;

  logic            run_c;
  logic            fast_c;
  logic            step_c;

`ifdef WIPER_MIST_EN
  logic            speed3_q, speed3_d;
  logic            mist_q, mist_d;
  logic            launch_c;

  // A mist request is the edge into speed==3; the current sweep stays fast only while 3 is held.
  always_comb begin
    speed3_d = (speed == 2'd3);
    launch_c = (speed == 2'd3) && !speed3_q;
    fast_c   = (speed == 2'd2) || (mist_q && (speed == 2'd3));
  end
`else
  // Speed 3 is treated as off, so only speed 2 selects the fast rate.
  always_comb begin
    fast_c = (speed == 2'd2);
  end
`endif

  // Step-rate divider compare; >= lets a slow->fast change step at once.
  always_comb begin
    run_c  = (speed == 2'd1) || (speed == 2'd2);
    step_c = (cnt_q >= (fast_c ? FAST_LAST : SLOW_LAST));
  end

  // Next-state, arm position, step counter and sweep counter.
  always_comb begin
    state_d       = state_q;
    arm_pos_d     = arm_pos_q;
    cnt_d         = cnt_q;
    sweep_count_d = sweep_count_q;
`ifdef WIPER_MIST_EN
    mist_d        = mist_q;
`endif
    case (state_q)
      PARK: begin
        arm_pos_d = '0;
        cnt_d     = '0;
        if (run_c) begin
          state_d = SWEEP_OUT;
        end
`ifdef WIPER_MIST_EN
        else if (launch_c) begin
          state_d = SWEEP_OUT;
          mist_d  = 1'b1;
        end
`endif
      end
      SWEEP_OUT: begin
        if (step_c) begin
          cnt_d     = '0;
          arm_pos_d = arm_pos_q + PW'(1);
          if (arm_pos_q == POS_TURN) begin
            state_d = SWEEP_BACK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SWEEP_BACK: begin
        if (step_c) begin
          cnt_d     = '0;
          arm_pos_d = arm_pos_q - PW'(1);
          if (arm_pos_q == POS_ONE) begin
            sweep_count_d = sweep_count_q + 8'd1;
`ifdef WIPER_MIST_EN
            mist_d        = 1'b0;
`endif
            if (speed == 2'd2) begin
              state_d = SWEEP_OUT;
            end else if (speed == 2'd1) begin
              state_d = DWELL;
            end else begin
              state_d = PARK;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DWELL: begin
        arm_pos_d = '0;
        if (speed == 2'd2) begin
          state_d = SWEEP_OUT;
          cnt_d   = '0;
        end else if (speed == 2'd1) begin
          if (cnt_q == DWELL_LAST) begin
            state_d = SWEEP_OUT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = PARK;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d   = PARK;
        arm_pos_d = '0;
        cnt_d     = '0;
      end
    endcase
  end

  // Display outputs are decoded from the next state so they register alongside it.
  always_comb begin
    led_bar_d = NPOS'(1) << arm_pos_d;
    moving_d  = (state_d == SWEEP_OUT) || (state_d == SWEEP_BACK);
    parked_d  = (state_d == PARK);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q       <= PARK;
      arm_pos_q     <= '0;
      cnt_q         <= '0;
      sweep_count_q <= '0;
      led_bar_q     <= NPOS'(1);
      moving_q      <= 1'b0;
      parked_q      <= 1'b1;
`ifdef WIPER_MIST_EN
      speed3_q      <= 1'b0;
      mist_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      arm_pos_q     <= arm_pos_d;
      cnt_q         <= cnt_d;
      sweep_count_q <= sweep_count_d;
      led_bar_q     <= led_bar_d;
      moving_q      <= moving_d;
      parked_q      <= parked_d;
`ifdef WIPER_MIST_EN
      speed3_q      <= speed3_d;
      mist_q        <= mist_d;
`endif
    end
  end

  assign arm_pos     = arm_pos_q;
  assign led_bar     = led_bar_q;
  assign moving      = moving_q;
  assign parked      = parked_q;
  assign sweep_count = sweep_count_q;

endmodule
